// File: rtl/f_window_fetch.sv
// f_window_fetch
// Fetch stage of the median filter pipeline. Raster-scans an IMG_DIM x IMG_DIM
// image from pixel memory, one read per cycle. Two line buffers and a 3x3
// shift window build the neighbourhood of every interior pixel, which is
// presented registered to the F->SO pipeline register.
//
// Ports
//   Clock       single clock, all state updates on posedge
//   Reset       synchronous, active-high
//   Start       one-cycle pulse, begins a frame scan when idle
//   MemRead     read strobe to pixel memory
//   MemAddr     read address {row, col}
//   MemData     read data, valid one cycle after MemRead
//   F_row       centre row of the current window
//   F_col       centre column of the current window
//   F_Window    F_Window[i][j] = pixel(F_row-1+i, F_col-1+j)
//   F_MemWrite  window valid; median is written at (F_row, F_col)
//   F_Enable    a pixel was processed this cycle
//   Busy        frame scan in progress
//   Done        one-cycle pulse at frame end
//
// state | meaning
// ------+-----------------------------------------------------
// IDLE  | waiting for Start
// READ  | one memory read per cycle, raster order
// DRAIN | reads finished, flushing the 2-cycle data pipeline
// DONE  | Done pulse, back to IDLE
module f_window_fetch #(
  parameter int IMG_DIM = 64,
  parameter int COORD_W = 6,
  parameter int PIX_W   = 8,
  parameter int ADDR_W  = 12
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Start,
  output logic                         MemRead,
  output logic [ADDR_W-1:0]            MemAddr,
  input  logic [PIX_W-1:0]             MemData,
  output logic [COORD_W-1:0]           F_row,
  output logic [COORD_W-1:0]           F_col,
  output logic [2:0][2:0][PIX_W-1:0]   F_Window,
  output logic                         F_MemWrite,
  output logic                         F_Enable,
  output logic                         Busy,
  output logic                         Done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  // DRAIN lasts two cycles; the down-counter is loaded with DRAIN_CYCLES-1.
  localparam int DRAIN_CYCLES = 2;
  localparam logic [1:0] DRAIN_LOAD = 2'(DRAIN_CYCLES - 1);

  state_t               state;
  logic [COORD_W-1:0]   rd_row;
  logic [COORD_W-1:0]   rd_col;
  logic [1:0]           drain_cnt;
  logic                 last_read;

  // Pixel tagging: MemData in this cycle belongs to the coordinates read
  // in the previous cycle.
  logic                 pix_valid;
  logic [COORD_W-1:0]   tag_row;
  logic [COORD_W-1:0]   tag_col;

  logic [PIX_W-1:0]     lb0 [IMG_DIM];  // previous row
  logic [PIX_W-1:0]     lb1 [IMG_DIM];  // row before that
  logic [2:0][2:0][PIX_W-1:0] win;
  logic [2:0][2:0][PIX_W-1:0] win_next;
  logic [2:0][PIX_W-1:0]      new_col;
  logic                 interior;

  assign MemAddr   = {rd_row, rd_col};
  assign last_read = (&rd_row) && (&rd_col);

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      rd_row    <= '0;
      rd_col    <= '0;
      drain_cnt <= '0;
      MemRead   <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            state   <= READ;
            rd_row  <= '0;
            rd_col  <= '0;
            MemRead <= 1'b1;
            Busy    <= 1'b1;
          end
        end
        READ: begin
          // The address increments as one ADDR_W counter so the column
          // wrap carries into the row; after (63,63) it returns to 0.
          {rd_row, rd_col} <= {rd_row, rd_col} + ADDR_W'(1);
          if (last_read) begin
            state     <= DRAIN;
            MemRead   <= 1'b0;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'd0) begin
            state <= DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 2'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Window assembly
  // ---------------------------------------------------------------------
  assign interior = (tag_row >= COORD_W'(2)) && (tag_col >= COORD_W'(2));

  always_comb begin
    new_col    = '0;
    new_col[0] = lb1[tag_col];
    new_col[1] = lb0[tag_col];
    new_col[2] = MemData;
    win_next   = '0;
    for (int i = 0; i < 3; i++) begin
      win_next[i][0] = win[i][1];
      win_next[i][1] = win[i][2];
      win_next[i][2] = new_col[i];
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pix_valid  <= 1'b0;
      tag_row    <= '0;
      tag_col    <= '0;
      win        <= '0;
      F_row      <= '0;
      F_col      <= '0;
      F_Window   <= '0;
      F_MemWrite <= 1'b0;
      F_Enable   <= 1'b0;
      for (int k = 0; k < IMG_DIM; k++) begin
        lb0[k] <= '0;
        lb1[k] <= '0;
      end
    end else begin
      pix_valid  <= MemRead;
      tag_row    <= rd_row;
      tag_col    <= rd_col;
      F_Enable   <= pix_valid;
      F_MemWrite <= pix_valid && interior;
      if (pix_valid) begin
        lb1[tag_col] <= lb0[tag_col];
        lb0[tag_col] <= MemData;
        win          <= win_next;
        // Columns left over from the previous row sit in win after a row
        // wrap; requiring col >= 2 guarantees two fresh shifts first.
        if (interior) begin
          F_row    <= tag_row - COORD_W'(1);
          F_col    <= tag_col - COORD_W'(1);
          F_Window <= win_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_f_window_fetch.sv
module tb_f_window_fetch;

  logic                    Clock = 1'b0;
  logic                    Reset = 1'b1;
  logic                    Start = 1'b0;
  logic                    MemRead;
  logic [11:0]             MemAddr;
  logic [7:0]              MemData = '0;
  logic [5:0]              F_row;
  logic [5:0]              F_col;
  logic [2:0][2:0][7:0]    F_Window;
  logic                    F_MemWrite;
  logic                    F_Enable;
  logic                    Busy;
  logic                    Done;

  f_window_fetch dut (
    .Clock(Clock), .Reset(Reset), .Start(Start),
    .MemRead(MemRead), .MemAddr(MemAddr), .MemData(MemData),
    .F_row(F_row), .F_col(F_col), .F_Window(F_Window),
    .F_MemWrite(F_MemWrite), .F_Enable(F_Enable),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'((3 * r + c) & 255);
  endfunction

  // Pixel memory: data valid one cycle after the read strobe.
  always @(posedge Clock) if (MemRead) MemData <= pix(int'(MemAddr[11:6]), int'(MemAddr[5:0]));

  typedef struct {
    int                   cyc;
    logic [5:0]           row;
    logic [5:0]           col;
    logic [2:0][2:0][7:0] win;
  } exp_t;

  exp_t sb[$];

  int tests = 0;
  int fails = 0;
  int exp_addr;
  int reads, first_read_cyc, last_read_cyc;
  int en_count, wr_count, done_count, done_cyc;
  int first_wr_cyc, last_wr_cyc, wrap_a_cyc, wrap_b_cyc;
  logic [5:0] last_row, last_col;
  logic [2:0][2:0][7:0] first_win, last_win, wrap_b_win;

  task automatic clear_stats();
    reads = 0; first_read_cyc = -1; last_read_cyc = -1;
    en_count = 0; wr_count = 0; done_count = 0; done_cyc = -1;
    first_wr_cyc = -1; last_wr_cyc = -1; wrap_a_cyc = -1; wrap_b_cyc = -1;
    last_row = '0; last_col = '0;
    first_win = '0; last_win = '0; wrap_b_win = '0;
    exp_addr = 0;
    sb.delete();
  endtask

  // Monitor and scoreboard, sampled on the falling edge.
  always @(negedge Clock) begin
    exp_t e;
    int r, c;
    if (MemRead) begin
      r = int'(MemAddr[11:6]);
      c = int'(MemAddr[5:0]);
      tests++;
      if (MemAddr !== 12'(exp_addr)) begin
        fails++;
        $display("FAIL mem_addr cyc=%0d got %0d want %0d", cyc, MemAddr, exp_addr);
      end
      exp_addr++;
      if (reads == 0) first_read_cyc = cyc;
      last_read_cyc = cyc;
      reads++;
      if (r >= 2 && c >= 2) begin
        e.cyc = cyc + 2;
        e.row = 6'(r - 1);
        e.col = 6'(c - 1);
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.win[i][j] = pix(r - 2 + i, c - 2 + j);
        sb.push_back(e);
      end
    end
    if (F_Enable) en_count++;
    if (Done) begin
      done_count++;
      done_cyc = cyc;
    end
    if (F_MemWrite) begin
      if (wr_count == 0) begin
        first_wr_cyc = cyc;
        first_win = F_Window;
      end
      wr_count++;
      last_wr_cyc = cyc;
      last_row = F_row;
      last_col = F_col;
      last_win = F_Window;
      if (F_row == 6'd1 && F_col == 6'd62) wrap_a_cyc = cyc;
      if (F_row == 6'd2 && F_col == 6'd1) begin
        wrap_b_cyc = cyc;
        wrap_b_win = F_Window;
      end
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_underflow cyc=%0d got window at (%0d,%0d) want none", cyc, F_row, F_col);
      end else begin
        e = sb.pop_front();
        if (cyc !== e.cyc || F_row !== e.row || F_col !== e.col || F_Window !== e.win) begin
          fails++;
          $display("FAIL window cyc=%0d got (%0d,%0d) %h want cyc=%0d (%0d,%0d) %h",
                   cyc, F_row, F_col, F_Window, e.cyc, e.row, e.col, e.win);
        end
      end
    end
  end

  task automatic wait_to(input int target);
    while (cyc < target) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Start = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b0;
    tests++;
    if ({MemRead, Busy, Done, F_Enable, F_MemWrite} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags got %b want 00000", {MemRead, Busy, Done, F_Enable, F_MemWrite});
    end
    tests++;
    if (MemAddr !== 12'd0) begin
      fails++;
      $display("FAIL reset_addr got %0d want 0", MemAddr);
    end
    tests++;
    if ({F_row, F_col} !== 12'd0 || F_Window !== '0) begin
      fails++;
      $display("FAIL reset_window got (%0d,%0d) %h want zero", F_row, F_col, F_Window);
    end
  endtask

  task automatic test_reset_start_same();
    clear_stats();
    Reset = 1'b1;
    Start = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    Start = 1'b0;
    tests++;
    if (MemRead !== 1'b0 || Busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_start_same got MemRead=%b Busy=%b want 0 0", MemRead, Busy);
    end
    repeat (5) @(posedge Clock);
    #1;
    tests++;
    if (reads != 0) begin
      fails++;
      $display("FAIL reset_start_reads got %0d want 0", reads);
    end
  endtask

  // Full frame with Start pulses during READ and DRAIN that must be ignored.
  task automatic test_full_frame(input string tag);
    int s;
    logic [2:0][2:0][7:0] w;
    clear_stats();
    s = cyc;
    Start = 1'b1;
    wait_to(s + 1);
    Start = 1'b0;
    tests++;
    if (MemRead !== 1'b1 || Busy !== 1'b1) begin
      fails++;
      $display("FAIL %s start_resp got MemRead=%b Busy=%b want 1 1", tag, MemRead, Busy);
    end
    wait_to(s + 10);
    Start = 1'b1;
    wait_to(s + 11);
    Start = 1'b0;
    wait_to(s + 4097);
    Start = 1'b1;
    wait_to(s + 4098);
    Start = 1'b0;
    tests++;
    if (Busy !== 1'b1 || MemRead !== 1'b0) begin
      fails++;
      $display("FAIL %s drain got Busy=%b MemRead=%b want 1 0", tag, Busy, MemRead);
    end
    wait_to(s + 4099);
    tests++;
    if (Busy !== 1'b0 || Done !== 1'b1) begin
      fails++;
      $display("FAIL %s done_cycle got Busy=%b Done=%b want 0 1", tag, Busy, Done);
    end
    wait_to(s + 4100);
    tests++;
    if (reads != 4096 || first_read_cyc != s + 1 || last_read_cyc != s + 4096) begin
      fails++;
      $display("FAIL %s reads got n=%0d %0d..%0d want 4096 %0d..%0d",
               tag, reads, first_read_cyc, last_read_cyc, s + 1, s + 4096);
    end
    tests++;
    if (en_count != 4096) begin
      fails++;
      $display("FAIL %s enable_count got %0d want 4096", tag, en_count);
    end
    tests++;
    if (wr_count != 3844) begin
      fails++;
      $display("FAIL %s write_count got %0d want 3844", tag, wr_count);
    end
    tests++;
    if (done_count != 1 || done_cyc != s + 4099) begin
      fails++;
      $display("FAIL %s done got n=%0d cyc=%0d want 1 cyc=%0d", tag, done_count, done_cyc, s + 4099);
    end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[i][j] = 8'(3 * i + j);
    tests++;
    if (first_wr_cyc != s + 133 || first_win !== w) begin
      fails++;
      $display("FAIL %s first_window got cyc=%0d %h want cyc=%0d %h", tag, first_wr_cyc, first_win, s + 133, w);
    end
    tests++;
    if (last_wr_cyc != s + 4098 || last_row !== 6'd62 || last_col !== 6'd62 || last_win[2][2] !== 8'd252) begin
      fails++;
      $display("FAIL %s last_window got cyc=%0d (%0d,%0d) px=%0d want cyc=%0d (62,62) px=252",
               tag, last_wr_cyc, last_row, last_col, last_win[2][2], s + 4098);
    end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[i][j] = 8'(3 * (i + 1) + j);
    tests++;
    if (wrap_a_cyc < 0 || wrap_b_cyc - wrap_a_cyc != 3 || wrap_b_win !== w) begin
      fails++;
      $display("FAIL %s row_wrap got gap=%0d %h want gap=3 %h", tag, wrap_b_cyc - wrap_a_cyc, wrap_b_win, w);
    end
    tests++;
    if (sb.size() != 0 || Busy !== 1'b0 || Done !== 1'b0) begin
      fails++;
      $display("FAIL %s frame_end got pending=%0d Busy=%b Done=%b want 0 0 0", tag, sb.size(), Busy, Done);
    end
  endtask

  // Entered directly from IDLE after a frame; the Start here opens a new frame.
  task automatic test_reset_mid_frame();
    int s;
    clear_stats();
    s = cyc;
    Start = 1'b1;
    wait_to(s + 1);
    Start = 1'b0;
    tests++;
    if (MemRead !== 1'b1 || MemAddr !== 12'd0) begin
      fails++;
      $display("FAIL restart_from_idle got MemRead=%b addr=%0d want 1 0", MemRead, MemAddr);
    end
    wait_to(s + 1000);
    Reset = 1'b1;
    wait_to(s + 1001);
    Reset = 1'b0;
    tests++;
    if ({MemRead, Busy, Done, F_Enable, F_MemWrite} !== 5'b0 || MemAddr !== 12'd0 ||
        {F_row, F_col} !== 12'd0 || F_Window !== '0) begin
      fails++;
      $display("FAIL mid_reset_outputs got flags=%b addr=%0d (%0d,%0d) %h want all zero",
               {MemRead, Busy, Done, F_Enable, F_MemWrite}, MemAddr, F_row, F_col, F_Window);
    end
    clear_stats();
    wait_to(s + 1200);
    tests++;
    if (reads != 0 || en_count != 0 || wr_count != 0 || done_count != 0 || Busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_quiet got reads=%0d en=%0d wr=%0d done=%0d busy=%b want 0 0 0 0 0",
               reads, en_count, wr_count, done_count, Busy);
    end
  endtask

  initial begin
    test_reset();
    test_reset_start_same();
    test_full_frame("frame");
    test_reset_mid_frame();
    test_full_frame("after_reset");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
